// File: rtl/config_regfile_if.sv
// Software-facing port of the configuration register bank: write handshake,
// read strobe and commit/abort control, with the pulses coming back.
interface config_regfile_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_shadow;
  logic [DATA_W-1:0] rd_data;

  logic              commit_req;
  logic              abort_req;
  logic              commit_done;
  logic              commit_err;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_en, rd_addr, rd_shadow,
    output commit_req, abort_req,
    input  wr_ready, wr_err, rd_data, commit_done, commit_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_en, rd_addr, rd_shadow,
    input  commit_req, abort_req,
    output wr_ready, wr_err, rd_data, commit_done, commit_err
  );
endinterface

// File: rtl/config_regfile.sv
// Shadow/active configuration register bank: software edits the shadow copy,
// a validated commit copies it atomically into the active copy.
module config_regfile #(
  parameter int          DATA_W        = 32,
  parameter int          NUM_REGS      = 8,
  parameter int          ADDR_W        = 3,
  parameter int unsigned DEF_THRESHOLD = 1000,
  parameter int unsigned DEF_RISK_MIN  = 1000,
  parameter int unsigned DEF_RISK_MAX  = 5000,
  parameter int          GEN_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  config_regfile_if.slave            bus,
  output logic [GEN_W-1:0]           cfg_gen_o,
  output logic [DATA_W-1:0]          trading_threshold_o,
  output logic [DATA_W-1:0]          risk_min_o,
  output logic [DATA_W-1:0]          risk_max_o,
  output logic [NUM_REGS*DATA_W-1:0] cfg_flat_o
);

  typedef enum logic [1:0] {
    Idle,
    Check,
    Apply
  } state_e;

  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W+1)'(NUM_REGS);

  state_e            state_q;
  logic              ready_q;
  logic              wrErr_q;
  logic              done_q;
  logic              cmtErr_q;
  logic [GEN_W-1:0]  gen_q;
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] rdData_q;
  logic [DATA_W-1:0] rdData_d;

  logic wrFire;
  logic wrAddrOk;
  logic abortFire;

  function automatic logic [DATA_W-1:0] resetVal(input int idx);
    case (idx)
      0:       return DATA_W'(DEF_THRESHOLD);
      1:       return DATA_W'(DEF_RISK_MIN);
      2:       return DATA_W'(DEF_RISK_MAX);
      default: return '0;
    endcase
  endfunction

  assign wrFire    = bus.wr_valid & ready_q;
  assign wrAddrOk  = {1'b0, bus.wr_addr} < NumRegsW;
  assign abortFire = (state_q == Idle) & bus.abort_req & ~bus.commit_req;

  // A write in the same cycle as an abort overrides the restored value at its address.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (abortFire) begin
        shadow_d[i] = active_q[i];
      end
      if (wrFire && (bus.wr_addr == ADDR_W'(i))) begin
        shadow_d[i] = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= resetVal(i);
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  always_comb begin
    rdData_d = rdData_q;
    if (bus.rd_en) begin
      rdData_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.rd_addr == ADDR_W'(i)) begin
          rdData_d = bus.rd_shadow ? shadow_q[i] : active_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData_q <= '0;
    end else begin
      rdData_q <= rdData_d;
    end
  end

  // The CHECK state sees the shadow after any write accepted alongside commit_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= Idle;
      ready_q  <= 1'b1;
      wrErr_q  <= 1'b0;
      done_q   <= 1'b0;
      cmtErr_q <= 1'b0;
      gen_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        active_q[i] <= resetVal(i);
      end
    end else begin
      wrErr_q  <= wrFire & ~wrAddrOk;
      done_q   <= 1'b0;
      cmtErr_q <= 1'b0;
      case (state_q)
        Idle: begin
          if (bus.commit_req) begin
            state_q <= Check;
            ready_q <= 1'b0;
          end
        end
        Check: begin
          if (shadow_q[1] <= shadow_q[2]) begin
            state_q <= Apply;
          end else begin
            state_q  <= Idle;
            ready_q  <= 1'b1;
            cmtErr_q <= 1'b1;
          end
        end
        Apply: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            active_q[i] <= shadow_q[i];
          end
          gen_q   <= gen_q + GEN_W'(1);
          done_q  <= 1'b1;
          state_q <= Idle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= Idle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_ready    = ready_q;
  assign bus.wr_err      = wrErr_q;
  assign bus.rd_data     = rdData_q;
  assign bus.commit_done = done_q;
  assign bus.commit_err  = cmtErr_q;

  assign cfg_gen_o           = gen_q;
  assign trading_threshold_o = active_q[0];
  assign risk_min_o          = active_q[1];
  assign risk_max_o          = active_q[2];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_flat_o[i*DATA_W +: DATA_W] = active_q[i];
    end
  end

endmodule

// File: tb/tb_config_regfile.sv
// Self-checking bench for config_regfile: reset read table, commit timing,
// rejected commit, abort, out-of-range access, backpressure and reset mid-commit.
module tb_config_regfile;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 3;
  localparam int GEN_W    = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  config_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [GEN_W-1:0]           cfgGen;
  logic [DATA_W-1:0]          threshold;
  logic [DATA_W-1:0]          riskMin;
  logic [DATA_W-1:0]          riskMax;
  logic [NUM_REGS*DATA_W-1:0] cfgFlat;

  config_regfile #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .DEF_THRESHOLD(1000), .DEF_RISK_MIN(1000), .DEF_RISK_MAX(5000), .GEN_W(GEN_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .cfg_gen_o(cfgGen),
    .trading_threshold_o(threshold),
    .risk_min_o(riskMin),
    .risk_max_o(riskMax),
    .cfg_flat_o(cfgFlat)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              shadow;
    logic [DATA_W-1:0] expData;
    string             name;
  } rdVec_t;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] rdExpQ[$];
  string             rdNameQ[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // One clock; a read issued before the edge is scored against its queued expectation.
  task automatic tick();
    logic hadRead;
    logic [DATA_W-1:0] expData;
    string name;
    hadRead = bus.rd_en;
    @(posedge clk);
    #1;
    if (hadRead && rdExpQ.size() > 0) begin
      expData = rdExpQ.pop_front();
      name    = rdNameQ.pop_front();
      checkOutput(name, bus.rd_data, expData);
    end
  endtask

  task automatic issueRead(input logic [ADDR_W-1:0] addr, input logic shadow,
                           input logic [DATA_W-1:0] expData, input string name);
    bus.rd_en     = 1'b1;
    bus.rd_addr   = addr;
    bus.rd_shadow = shadow;
    rdExpQ.push_back(expData);
    rdNameQ.push_back(name);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic wrValid, input logic [ADDR_W-1:0] wrAddr,
                               input logic [DATA_W-1:0] wrData, input logic commit, input logic abort);
    bus.wr_valid   = wrValid;
    bus.wr_addr    = wrAddr;
    bus.wr_data    = wrData;
    bus.commit_req = commit;
    bus.abort_req  = abort;
    tick();
    bus.wr_valid   = 1'b0;
    bus.commit_req = 1'b0;
    bus.abort_req  = 1'b0;
  endtask

  task automatic writeShadow(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    int waitCycles;
    waitCycles   = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    while (!bus.wr_ready && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!bus.wr_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL write_timeout actual=ready_low required=ready_high");
    end else begin
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic doCommit(input logic expectOk, input logic [GEN_W-1:0] expGen);
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    checkOutput("ready_in_check", bus.wr_ready, 0);
    tick();
    if (expectOk) begin
      checkOutput("ready_in_apply", bus.wr_ready, 0);
      checkOutput("done_early", bus.commit_done, 0);
      tick();
      checkOutput("commit_done", bus.commit_done, 1);
      checkOutput("ready_after_apply", bus.wr_ready, 1);
      checkOutput("gen_after_commit", cfgGen, expGen);
      tick();
      checkOutput("done_one_cycle", bus.commit_done, 0);
    end else begin
      checkOutput("commit_err", bus.commit_err, 1);
      checkOutput("ready_after_err", bus.wr_ready, 1);
      checkOutput("gen_after_err", cfgGen, expGen);
      tick();
      checkOutput("err_one_cycle", bus.commit_err, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rdVec_t vecs[$];
    int lowCycles;
    int n;
    logic doneSeen;

    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_shadow  = 1'b0;
    bus.commit_req = 1'b0;
    bus.abort_req  = 1'b0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_gen", cfgGen, 0);
    checkOutput("reset_ready", bus.wr_ready, 1);
    checkOutput("reset_threshold", threshold, 1000);
    checkOutput("reset_risk_min", riskMin, 1000);
    checkOutput("reset_risk_max", riskMax, 5000);
    checkOutput("reset_rd_data", bus.rd_data, 0);
    checkOutput("reset_done", bus.commit_done, 0);
    checkOutput("reset_wr_err", bus.wr_err, 0);

    vecs.push_back('{3'd0, 1'b0, 32'd1000, "act0_reset"});
    vecs.push_back('{3'd1, 1'b0, 32'd1000, "act1_reset"});
    vecs.push_back('{3'd2, 1'b0, 32'd5000, "act2_reset"});
    vecs.push_back('{3'd3, 1'b0, 32'd0,    "act3_reset"});
    vecs.push_back('{3'd4, 1'b0, 32'd0,    "act4_reset"});
    vecs.push_back('{3'd7, 1'b0, 32'd0,    "act7_out_of_range"});
    vecs.push_back('{3'd0, 1'b1, 32'd1000, "sh0_reset"});
    vecs.push_back('{3'd2, 1'b1, 32'd5000, "sh2_reset"});
    for (int i = 0; i < vecs.size(); i++) begin
      issueRead(vecs[i].addr, vecs[i].shadow, vecs[i].expData, vecs[i].name);
    end

    writeShadow(3'd0, 32'd2500);
    writeShadow(3'd2, 32'd8000);
    checkOutput("threshold_before_commit", threshold, 1000);
    checkOutput("risk_max_before_commit", riskMax, 5000);
    issueRead(3'd0, 1'b1, 32'd2500, "sh0_edited");
    issueRead(3'd0, 1'b0, 32'd1000, "act0_before_commit");
    doCommit(1'b1, 16'd1);
    checkOutput("threshold_commit1", threshold, 2500);
    checkOutput("risk_max_commit1", riskMax, 8000);
    checkOutput("risk_min_commit1", riskMin, 1000);
    checkOutput("flat_slice0", cfgFlat[31:0], 2500);
    checkOutput("flat_slice2", cfgFlat[95:64], 8000);

    writeShadow(3'd1, 32'd9000);
    doCommit(1'b0, 16'd1);
    checkOutput("risk_min_rejected", riskMin, 1000);
    issueRead(3'd1, 1'b1, 32'd9000, "sh1_retained");
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
    issueRead(3'd1, 1'b1, 32'd1000, "sh1_aborted");
    issueRead(3'd0, 1'b1, 32'd2500, "sh0_after_abort");

    writeShadow(3'd7, 32'hDEAD_BEEF);
    checkOutput("wr_err_pulse", bus.wr_err, 1);
    tick();
    checkOutput("wr_err_cleared", bus.wr_err, 0);
    issueRead(3'd7, 1'b1, 32'd0, "sh7_dropped");
    issueRead(3'd7, 1'b0, 32'd0, "act7_dropped");
    writeShadow(3'd4, 32'd77);
    checkOutput("wr_err_last_addr", bus.wr_err, 0);
    issueRead(3'd4, 1'b1, 32'd77, "sh4_last_addr");
    checkOutput("threshold_unchanged", threshold, 2500);

    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    bus.wr_valid   = 1'b1;
    bus.wr_addr    = 3'd3;
    bus.wr_data    = 32'd55;
    lowCycles = 0;
    n = 0;
    while (!bus.wr_ready && n < 10) begin
      lowCycles++;
      tick();
      n++;
    end
    checkOutput("ready_low_cycles", lowCycles, 2);
    checkOutput("done_backpressure", bus.commit_done, 1);
    checkOutput("gen_commit2", cfgGen, 2);
    tick();
    bus.wr_valid = 1'b0;
    checkOutput("flat_slice4", cfgFlat[159:128], 77);
    issueRead(3'd3, 1'b1, 32'd55, "sh3_held_write");
    issueRead(3'd3, 1'b0, 32'd0, "act3_not_committed");

    applyStimulus(1'b1, 3'd0, 32'd3333, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("done_same_cycle", bus.commit_done, 1);
    checkOutput("threshold_same_cycle", threshold, 3333);
    checkOutput("gen_commit3", cfgGen, 3);
    checkOutput("flat_slice3", cfgFlat[127:96], 55);
    issueRead(3'd3, 1'b1, 32'd55, "sh3_abort_ignored");

    writeShadow(3'd0, 32'd4444);
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_threshold", threshold, 1000);
    checkOutput("async_risk_min", riskMin, 1000);
    checkOutput("async_risk_max", riskMax, 5000);
    checkOutput("async_gen", cfgGen, 0);
    checkOutput("async_ready", bus.wr_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    doneSeen = 1'b0;
    repeat (4) begin
      tick();
      if (bus.commit_done) doneSeen = 1'b1;
    end
    checkOutput("no_done_after_reset", doneSeen, 0);
    checkOutput("threshold_after_reset", threshold, 1000);
    issueRead(3'd0, 1'b1, 32'd1000, "sh0_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
